// File: rtl/fxmul_pkg.sv
// Shared types and helpers for the fxmul arbiter slice.
// FXMUL_SAT_EN selects saturating instead of wrapping results.
package fxmul_pkg;

  localparam int WORD_W    = 32;
  localparam int FRAC_BITS = 10;
  localparam int PROD_W    = 2 * WORD_W;
  localparam int MAX_REQ   = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n
  );
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = (int'(ptr) + i) % n;
      if (i < n && !r.found && valid[k[2:0]]) begin
        r.found = 1'b1;
        r.idx   = k[2:0];
      end
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] fx_result(
    input logic signed [PROD_W-1:0] p
  );
    logic [WORD_W-1:0] r;
    r = p[WORD_W+FRAC_BITS-1:FRAC_BITS];
`ifdef FXMUL_SAT_EN
    // upper bits must all match the result sign bit
    if (p[PROD_W-1:WORD_W+FRAC_BITS-1] !=
        {(PROD_W-WORD_W-FRAC_BITS+1){p[PROD_W-1]}}) begin
      r = p[PROD_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/fxmul_if.sv
// Requester-side bundle of the shared fixed-point multiplier:
// per-requester operand handshake plus one-hot response strobe.
interface fxmul_if
  import fxmul_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][WORD_W-1:0] req_a;
  logic [NUM_REQ-1:0][WORD_W-1:0] req_b;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [WORD_W-1:0]              rsp_data;
  logic                           idle;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, idle
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, idle
  );
endinterface

// File: rtl/fxmul_pipe.sv
// LATENCY-stage Q22.10 multiply pipeline carrying a one-hot id;
// a non-zero id marks a valid stage.
module fxmul_pipe
  import fxmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] in_id,
  input  logic [WORD_W-1:0]  in_a,
  input  logic [WORD_W-1:0]  in_b,
  output logic [NUM_REQ-1:0] out_id,
  output logic [WORD_W-1:0]  out_data,
  output logic               busy
);

  localparam int NPS = (LATENCY > 2) ? LATENCY - 2 : 1;

  logic [WORD_W-1:0]        a_q, a_d;
  logic [WORD_W-1:0]        b_q, b_d;
  logic [NUM_REQ-1:0]       id_q, id_d;
  logic signed [PROD_W-1:0] prod_q [NPS];
  logic signed [PROD_W-1:0] prod_d [NPS];
  logic [NUM_REQ-1:0]       pid_q [NPS];
  logic [NUM_REQ-1:0]       pid_d [NPS];
  logic [NUM_REQ-1:0]       rid_q, rid_d;
  logic [WORD_W-1:0]        res_q, res_d;

  logic signed [PROD_W-1:0] mul;
  logic signed [PROD_W-1:0] last_p;
  logic [NUM_REQ-1:0]       last_id;

  always_comb begin
    a_d  = (|in_id) ? in_a : a_q;
    b_d  = (|in_id) ? in_b : b_q;
    id_d = in_id;
    mul  = PROD_W'($signed(a_q)) *
           PROD_W'($signed(b_q));
    prod_d[0] = mul;
    pid_d[0]  = id_q;
    for (int i = 1; i < NPS; i++) begin
      prod_d[i] = prod_q[i-1];
      pid_d[i]  = pid_q[i-1];
    end
    // with only two stages the product feeds the result stage directly
    if (LATENCY > 2) begin
      last_p  = prod_q[NPS-1];
      last_id = pid_q[NPS-1];
    end else begin
      last_p  = mul;
      last_id = id_q;
    end
    rid_d = last_id;
    res_d = (|last_id) ? fx_result(last_p) : '0;
    busy  = (|id_q) | (|rid_q);
    if (LATENCY > 2) begin
      for (int i = 0; i < NPS; i++) begin
        busy = busy | (|pid_q[i]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
      rid_q <= '0;
      res_q <= '0;
      for (int i = 0; i < NPS; i++) begin
        prod_q[i] <= '0;
        pid_q[i]  <= '0;
      end
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      id_q  <= id_d;
      rid_q <= rid_d;
      res_q <= res_d;
      for (int i = 0; i < NPS; i++) begin
        prod_q[i] <= prod_d[i];
        pid_q[i]  <= pid_d[i];
      end
    end
  end

  assign out_id   = rid_q;
  assign out_data = res_q;

endmodule

// File: rtl/fxmul_arbiter.sv
// Round-robin share of one Q22.10 multiplier among NUM_REQ requesters.
// Define FXMUL_SAT_EN for saturating results.
module fxmul_arbiter
  import fxmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input logic  clock,
  input logic  reset_n,
  fxmul_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;
  logic [NUM_REQ-1:0] grant;
  logic [WORD_W-1:0]  sel_a, sel_b;
  logic               busy;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = bus.req_valid;
    pick  = rr_pick(valid_ext, 3'(ptr_q), NUM_REQ);
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    ptr_d = ptr_q;
    // no grants while reset is held
    if (reset_n && pick.found) begin
      grant[pick.idx[PW-1:0]] = 1'b1;
      sel_a = bus.req_a[pick.idx[PW-1:0]];
      sel_b = bus.req_b[pick.idx[PW-1:0]];
      if (int'(pick.idx) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick.idx[PW-1:0] + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  fxmul_pipe #(
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_id    (grant),
    .in_a     (sel_a),
    .in_b     (sel_b),
    .out_id   (bus.rsp_valid),
    .out_data (bus.rsp_data),
    .busy     (busy)
  );

  assign bus.req_ready = grant;
  assign bus.idle      = ~(|grant) & ~busy;

endmodule
